// File: rtl/sc_micro_sequencer.sv
// Microsequencer: owns the uPC, picks the next control-store address from the
// MIR fields, flags and IR, and runs the MIR-load / commit / memory handshake.
module sc_micro_sequencer #(
  parameter int                        DATAWIDTH_ADDR = 11,
  parameter logic [DATAWIDTH_ADDR-1:0] RESET_ADDR     = '0,
  parameter int                        MEM_TIMEOUT    = 16,
  parameter int                        TIMEOUT_WIDTH  = 8
) (
  input  logic                      SC_MicroSeq_CLOCK_50,
  input  logic                      SC_MicroSeq_Reset_InHigh,
  input  logic [2:0]                SC_MicroSeq_COND_In,
  input  logic [DATAWIDTH_ADDR-1:0] SC_MicroSeq_JMPADDR_In,
  input  logic                      SC_MicroSeq_RD_In,
  input  logic                      SC_MicroSeq_WR_In,
  input  logic [3:0]                SC_MicroSeq_Flags_In,
  input  logic [31:0]               SC_MicroSeq_IR_In,
  input  logic                      SC_MicroSeq_MemAck_InHigh,
  input  logic                      SC_MicroSeq_Halt_InHigh,
  output logic [DATAWIDTH_ADDR-1:0] SC_MicroSeq_CSAddress_Out,
  output logic                      SC_MicroSeq_MIRWrite_OutHigh,
  output logic                      SC_MicroSeq_Exec_OutHigh,
  output logic                      SC_MicroSeq_MemReq_OutHigh,
  output logic                      SC_MicroSeq_BusError_OutHigh,
  output logic [2:0]                SC_MicroSeq_State_Out
);

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_MEMWAIT = 3'd2,
    ST_HALT    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [DATAWIDTH_ADDR-1:0] upc_q, upc_d;
  logic [TIMEOUT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                      berr_q, berr_d;

  logic [DATAWIDTH_ADDR-1:0] upc_inc;
  logic [DATAWIDTH_ADDR-1:0] decode_addr;
  logic [DATAWIDTH_ADDR-1:0] next_addr;
  logic                      mem_op;
  logic                      complete;
  logic                      unused_ir;

  assign unused_ir   = ^{SC_MicroSeq_IR_In[29:25], SC_MicroSeq_IR_In[18:14], SC_MicroSeq_IR_In[12:0]};
  assign upc_inc     = upc_q + 1'b1;
  assign decode_addr = DATAWIDTH_ADDR'({1'b1, SC_MicroSeq_IR_In[31:30], SC_MicroSeq_IR_In[24:19], 2'b00});
  assign mem_op      = SC_MicroSeq_RD_In | SC_MicroSeq_WR_In;

  always_comb begin
    next_addr = upc_inc;
    unique case (SC_MicroSeq_COND_In)
      3'b001:  if (SC_MicroSeq_Flags_In[3]) next_addr = SC_MicroSeq_JMPADDR_In;
      3'b010:  if (SC_MicroSeq_Flags_In[2]) next_addr = SC_MicroSeq_JMPADDR_In;
      3'b011:  if (SC_MicroSeq_Flags_In[1]) next_addr = SC_MicroSeq_JMPADDR_In;
      3'b100:  if (SC_MicroSeq_Flags_In[0]) next_addr = SC_MicroSeq_JMPADDR_In;
      3'b101:  if (SC_MicroSeq_IR_In[13])   next_addr = SC_MicroSeq_JMPADDR_In;
      3'b110:  next_addr = SC_MicroSeq_JMPADDR_In;
      3'b111:  next_addr = decode_addr;
      default: next_addr = upc_inc;
    endcase
  end

  always_ff @(posedge SC_MicroSeq_CLOCK_50 or posedge SC_MicroSeq_Reset_InHigh) begin
    if (SC_MicroSeq_Reset_InHigh) begin
      state_q <= ST_LOAD;
      upc_q   <= RESET_ADDR;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d                      = state_q;
    upc_d                        = upc_q;
    cnt_d                        = cnt_q;
    berr_d                       = berr_q;
    complete                     = 1'b0;
    SC_MicroSeq_MIRWrite_OutHigh = 1'b0;
    SC_MicroSeq_Exec_OutHigh     = 1'b0;
    SC_MicroSeq_MemReq_OutHigh   = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        SC_MicroSeq_MIRWrite_OutHigh = 1'b1;
        state_d                      = ST_EXEC;
      end
      ST_EXEC: begin
        // uPC advances even for memory ops; flags/IR are only valid this cycle.
        cnt_d = '0;
        upc_d = next_addr;
        if (mem_op) begin
          SC_MicroSeq_MemReq_OutHigh = 1'b1;
          if (SC_MicroSeq_MemAck_InHigh) complete = 1'b1;
          else                           state_d  = ST_MEMWAIT;
        end else begin
          complete = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        SC_MicroSeq_MemReq_OutHigh = 1'b1;
        if (SC_MicroSeq_MemAck_InHigh) begin
          complete = 1'b1;
        end else if (cnt_q == TIMEOUT_WIDTH'(MEM_TIMEOUT - 1)) begin
          state_d = ST_ERROR;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HALT: begin
        if (!SC_MicroSeq_Halt_InHigh) state_d = ST_LOAD;
      end
      ST_ERROR: begin
        berr_d = 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase

    if (complete) begin
      SC_MicroSeq_Exec_OutHigh = 1'b1;
      state_d = SC_MicroSeq_Halt_InHigh ? ST_HALT : ST_LOAD;
    end
  end

  assign SC_MicroSeq_CSAddress_Out    = upc_q;
  assign SC_MicroSeq_BusError_OutHigh = berr_q;
  assign SC_MicroSeq_State_Out        = state_q;

endmodule

// File: doc/sc_micro_sequencer.md
Name: sc_micro_sequencer

Overview:
Control-unit microsequencer for the microprogrammed datapath. It holds the microprogram counter (uPC), computes the next control-store address from the MIR fields (COND, JMP_ADDR, RD, WR), the ALU flags and the IR. It generates the MIR load enable, the datapath commit strobe and the memory request/acknowledge handshake. It sits between the control-store ROM, the MIR register and the datapath/memory interface.

Parameters:
DATAWIDTH_ADDR, 11, control-store address width (uPC, JMP_ADDR, CSAddress).
RESET_ADDR, 11'd0, uPC value after reset.
MEM_TIMEOUT, 16, maximum MEMWAIT cycles without acknowledge before bus error (>=1).
TIMEOUT_WIDTH, 8, width of the memory wait counter (must hold MEM_TIMEOUT-1).

Ports:
SC_MicroSeq_CLOCK_50  in  1  system clock; all state changes on rising edge.
SC_MicroSeq_Reset_InHigh  in  1  asynchronous, active-high reset.
SC_MicroSeq_COND_In  in  3  MIR COND field.
SC_MicroSeq_JMPADDR_In  in  11  MIR JMP_ADDR field.
SC_MicroSeq_RD_In  in  1  MIR RD bit (memory read microinstruction).
SC_MicroSeq_WR_In  in  1  MIR WR bit (memory write microinstruction).
SC_MicroSeq_Flags_In  in  4  PSR flags {n,z,v,c} (bit3..bit0).
SC_MicroSeq_IR_In  in  32  instruction register (uses bits 31:30, 24:19, 13).
SC_MicroSeq_MemAck_InHigh  in  1  memory transfer complete.
SC_MicroSeq_Halt_InHigh  in  1  halt request (debug/step).
SC_MicroSeq_CSAddress_Out  out  11  uPC, drives control-store address.
SC_MicroSeq_MIRWrite_OutHigh  out  1  MIR load enable (MIR captures on falling edge).
SC_MicroSeq_Exec_OutHigh  out  1  datapath commit strobe, exactly one cycle per microinstruction.
SC_MicroSeq_MemReq_OutHigh  out  1  memory request, held until ack.
SC_MicroSeq_BusError_OutHigh  out  1  sticky memory-timeout error.
SC_MicroSeq_State_Out  out  3  current FSM state (debug).

Behaviour:
- Reset (async, any state, including mid-MEMWAIT): state=LOAD, uPC=RESET_ADDR, wait counter=0, BusError=0. Resulting outputs: MIRWrite=1, Exec=0, MemReq=0.
- State encoding: LOAD=0, EXEC=1, MEMWAIT=2, HALT=3, ERROR=4.
- LOAD: MIRWrite=1; MIR captures CS[uPC] on this cycle's falling edge. Next state is always EXEC.
- EXEC: MIRWrite=0; wait counter cleared; uPC <= NextAddr at the end of the cycle (always, also for memory ops).
  - If RD|WR: MemReq=1 combinationally.
    - MemAck=1 in this cycle: Exec=1 and the microinstruction completes.
    - Otherwise: go to MEMWAIT, Exec=0.
  - If not RD|WR: Exec=1 and the microinstruction completes.
- MEMWAIT: MemReq=1; uPC held.
  - MemAck=1: Exec=1 and the microinstruction completes.
  - Else if counter==MEM_TIMEOUT-1: go to ERROR and set BusError=1.
  - Else counter+1.
  - Ack and timeout in the same cycle: ack wins.
- Completion: go to HALT if Halt_In=1 in that cycle, else go to LOAD.
- HALT: all strobes 0; uPC held. Stay while Halt_In=1; go to LOAD when Halt_In=0.
- ERROR: all strobes 0; BusError=1. Stays until reset.
- Throughput: a non-memory microinstruction takes 2 cycles (LOAD, EXEC). A memory microinstruction takes 2 + wait cycles.
- NextAddr, combinational from MIR fields, flags and IR during EXEC:
  - 000: uPC+1.
  - 001: JMP_ADDR if n, else uPC+1.
  - 010: JMP_ADDR if z, else uPC+1.
  - 011: JMP_ADDR if v, else uPC+1.
  - 100: JMP_ADDR if c, else uPC+1.
  - 101: JMP_ADDR if IR[13], else uPC+1.
  - 110: JMP_ADDR unconditionally.
  - 111: decode = {1'b1, IR[31:30], IR[24:19], 2'b00}.
- uPC+1 is modulo 2^11: 2047 wraps to 0.
- Flags and IR are sampled only in the EXEC cycle. Changes during MEMWAIT do not alter the already-updated uPC.
- All outputs except MemReq/Exec are registered or state-decoded. MemReq and Exec also depend on RD/WR/MemAck in the current cycle.

Test Plan:
1. Assert then release reset -> CSAddress=0, State=0, MIRWrite=1. Next cycle State=1, MIRWrite=0, Exec=1 (MIR=0, COND=000). Following cycle CSAddress=1.
2. uPC=5, COND=000 -> CSAddress=6. Then force uPC=2047, COND=000 -> CSAddress=0 (wrap).
3. COND=010, JMP=0x1A0: Flags=4'b0100 -> uPC=0x1A0. Flags=4'b0000 from uPC=0x10 -> uPC=0x11. Repeat for COND 001/011/100/101/110 with the matching flag/IR[13] set and clear.
4. COND=111, IR[31:30]=2'b10, IR[24:19]=6'b010000 -> CSAddress=0x640.
5. RD=1, MemAck rises on the 3rd MEMWAIT cycle -> MemReq high 4 consecutive cycles, Exec single pulse on the ack cycle, then State=LOAD. Repeat with ack during EXEC -> no MEMWAIT visit. Assert reset during MEMWAIT -> State=0, MemReq=0 immediately.
6. WR=1, MemAck never asserted, MEM_TIMEOUT=16 -> 16 MEMWAIT cycles, then State=4, BusError=1, MemReq=0 held until reset. Separately, Halt_In=1 at completion -> State=3 with uPC held. Release Halt_In -> LOAD next cycle.
